// File: rtl/led_sequence_ctrl.sv
// led_sequence_ctrl: debounced start/stop run-control for a RED/BLUE/GREEN status LED sequence
module led_sequence_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PHASE_CYCLES    = 30_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_0,
  input  logic       button_1,
  output logic [2:0] led,
  output logic       running,
  output logic [1:0] phase,
  output logic [7:0] cycle_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(PHASE_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(PHASE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state, state_nx;
  logic [1:0] btn, sync_a, sync_b, db, db_d, press;
  logic [DW-1:0] db_cnt [2];
  logic [TW-1:0] timer, timer_nx;
  logic [1:0] phase_nx;
  logic [7:0] cycle_nx;
  logic stop_p, start_p, wrap;
  assign btn = {button_1, button_0};
  assign stop_p = press[0];
  assign start_p = press[1];
  assign wrap = timer == T_LAST;
  // two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  // debounced level follows the synchronised level only after a stable run
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db <= '1;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else
      for (int i = 0; i < 2; i++)
        if (sync_b[i] == db[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == DB_MAX) begin
          db[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else db_cnt[i] <= db_cnt[i] + 1'b1;
  // one-cycle press pulses on debounced falling edges; releases are ignored
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      db_d <= '1;
      press <= '0;
    end else begin
      db_d <= db;
      press <= db_d & ~db;
    end
  // next state: stop beats start everywhere, and a stop on a terminal cycle blocks the advance
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    phase_nx = phase;
    cycle_nx = cycle_count;
    if (stop_p) begin
      if (state == RUN) state_nx = PAUSE;
      else if (state == PAUSE) begin
        state_nx = IDLE;
        timer_nx = '0;
        phase_nx = '0;
        cycle_nx = '0;
      end
    end else if (start_p) begin
      state_nx = RUN;
      timer_nx = state == PAUSE ? timer : '0;
      phase_nx = state == PAUSE ? phase : '0;
    end else if (state == RUN) begin
      timer_nx = wrap ? '0 : timer + 1'b1;
      phase_nx = !wrap ? phase : phase == 2'd2 ? 2'd0 : phase + 2'd1;
      cycle_nx = wrap && phase == 2'd2 && cycle_count != 8'hff ? cycle_count + 8'd1 : cycle_count;
    end
  end
  // sequencer registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      phase <= '0;
      cycle_count <= '0;
      running <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      phase <= phase_nx;
      cycle_count <= cycle_nx;
      running <= state_nx == RUN;
    end
  // active-low LED colour, one cycle behind the phase register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) led <= 3'b111;
    else led <= state == IDLE ? 3'b111 : phase == 2'd0 ? 3'b110 : phase == 2'd1 ? 3'b011 : 3'b101;
endmodule
